fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//   Instruction-fetch initiator that drives the icache lookup port (addr in; data, hit out).
//   Holds the PC, presents it to the icache every cycle and waits on misses.
//   Delivers fetched words to decode with a valid flag, and honours decode stall and branch redirect.
//   Keeps miss/miss-cycle performance counters.
//   Sits between the icache and the decode stage.
// PARAMETERS
//   RESET_PC   32'h00400000  PC loaded on reset (MIPS .text base)
//   CNT_W      16            width of the performance counters
// PORTS
//   clk          in   1      clock, rising edge
//   reset        in   1      asynchronous, active-low (0 = in reset)
//   ic_addr      out  32     fetch address to icache (= pc register)
//   ic_data      in   32     icache read data, valid when ic_hit=1
//   ic_hit       in   1      icache hit for current ic_addr, same-cycle
//   stall        in   1      decode cannot accept; freeze fetch and outputs
//   flush        in   1      branch/jump redirect strobe
//   redirect_pc  in   32     new PC, sampled when flush=1
//   inst         out  32     instruction to decode
//   inst_pc      out  32     address of inst
//   inst_valid   out  1      inst/inst_pc valid this cycle
//   miss_count   out  CNT_W  number of miss events
//   miss_cycles  out  CNT_W  cycles spent in MISS
// BEHAVIOUR
//   Reset (reset=0, async): pc=RESET_PC, state=IDLE, inst=0, inst_pc=0, inst_valid=0, both counters=0.
//   ic_addr is driven combinationally from pc. The icache answers in the same cycle.
//   States: IDLE, FETCH, MISS. All registers update on the rising clk edge only.
//   IDLE: lasts exactly 1 cycle after reset deasserts. inst_valid=0, pc unchanged, then -> FETCH.
//     ic_hit is ignored in IDLE.
//   Per-edge priority: flush > stall > hit/miss.
//   flush=1 (any state, including IDLE):
//     pc <= {redirect_pc[31:2],2'b00}; inst_valid <= 0; state <= FETCH.
//     The current hit is discarded. flush overrides stall.
//   stall=1 (no flush): pc, inst, inst_pc, inst_valid and state all hold.
//     miss_cycles still increments while in MISS.
//   FETCH, ic_hit=1: inst<=ic_data, inst_pc<=pc, inst_valid<=1, pc<=pc+4.
//   FETCH, ic_hit=0: inst_valid<=0, pc holds, state<=MISS, miss_count++.
//   MISS, ic_hit=0: inst_valid<=0, pc holds, miss_cycles++.
//   MISS, ic_hit=1: deliver as in FETCH-hit; miss_cycles++; state<=FETCH.
//   Latency: hit at pc in cycle N -> inst_valid=1 with that word in cycle N+1.
//     Back-to-back hits give one instruction per cycle.
//   PC arithmetic: 32-bit modulo, so 32'hFFFFFFFC+4 -> 32'h00000000. pc[1:0] is always 00.
//   Counters saturate at all-ones and never wrap. Only reset clears them.
//   Reset asserted mid-miss or mid-stall: immediate return to reset values. No stale inst_valid.
// TESTING
//   1. Reset then release, ic_hit=1 constant, ic_data=pc^32'hA5A5A5A5
//      -> IDLE 1 cycle; then inst_pc=00400000,00400004,00400008 on consecutive cycles, inst_valid=1.
//   2. ic_hit=0 for 3 cycles at pc 00400040, then hit with data 32'h1234
//      -> inst_valid=0 for the 3 bubble cycles; inst=32'h1234, inst_pc=00400040 next; miss_count=1, miss_cycles=3.
//   3. stall=1 for 2 cycles after inst_pc=00400004 is valid
//      -> inst/inst_pc/inst_valid frozen 2 cycles; then 00400008 follows with no skip or duplicate.
//   4. flush=1, redirect_pc=0030e042, during MISS with stall=1
//      -> next ic_addr=0030e040, inst_valid=0, state FETCH, miss_count unchanged.
//   5. flush to FFFFFFFC, hits -> inst_pc FFFFFFFC then 00000000.
//      Also: force 2^CNT_W+3 misses -> miss_count stays FFFF (CNT_W=16).
//   6. Assert reset during MISS -> outputs 0, ic_addr=00400000 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: presents the PC to the icache each cycle, waits out misses,
// and hands fetched words to decode with stall/redirect support and saturating miss counters.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0040_0000,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   output logic [31:0]      ic_addr,
   input  logic [31:0]      ic_data,
   input  logic             ic_hit,
   input  logic             stall,
   input  logic             flush,
   input  logic [31:0]      redirect_pc,
   output logic [31:0]      inst,
   output logic [31:0]      inst_pc,
   output logic             inst_valid,
   output logic [CNT_W-1:0] miss_count,
   output logic [CNT_W-1:0] miss_cycles
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_MISS  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [31:0]        pc_q, pc_d;
   logic [31:0]        inst_q, inst_d;
   logic [31:0]        inst_pc_q, inst_pc_d;
   logic               inst_valid_q, inst_valid_d;
   logic [CNT_W-1:0]   miss_count_q, miss_count_d;
   logic [CNT_W-1:0]   miss_cycles_q, miss_cycles_d;

   // Counters stick at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      logic [CNT_W-1:0] r;
      if (&v) begin
         r = v;
      end else begin
         r = v + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      return r;
   endfunction

   // Next-state logic; priority per edge is flush, then stall, then hit/miss.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      inst_d        = inst_q;
      inst_pc_d     = inst_pc_q;
      inst_valid_d  = inst_valid_q;
      miss_count_d  = miss_count_q;
      miss_cycles_d = miss_cycles_q;

      // Every cycle spent in MISS is counted, whatever else happens on that edge.
      if (state_q == ST_MISS) begin
         miss_cycles_d = sat_inc(miss_cycles_q);
      end else begin
         miss_cycles_d = miss_cycles_q;
      end

      if (flush) begin
         pc_d         = redirect_pc & 32'hFFFF_FFFC;
         inst_valid_d = 1'b0;
         state_d      = ST_FETCH;
      end else if (stall) begin
         state_d      = state_q;
         inst_valid_d = inst_valid_q;
      end else begin
         case (state_q)
            ST_IDLE: begin
               inst_valid_d = 1'b0;
               state_d      = ST_FETCH;
            end
            ST_FETCH: begin
               if (ic_hit) begin
                  inst_d       = ic_data;
                  inst_pc_d    = pc_q;
                  inst_valid_d = 1'b1;
                  pc_d         = pc_q + 32'd4;
               end else begin
                  inst_valid_d = 1'b0;
                  miss_count_d = sat_inc(miss_count_q);
                  state_d      = ST_MISS;
               end
            end
            ST_MISS: begin
               if (ic_hit) begin
                  inst_d       = ic_data;
                  inst_pc_d    = pc_q;
                  inst_valid_d = 1'b1;
                  pc_d         = pc_q + 32'd4;
                  state_d      = ST_FETCH;
               end else begin
                  inst_valid_d = 1'b0;
               end
            end
            default: begin
               inst_valid_d = 1'b0;
               state_d      = ST_IDLE;
            end
         endcase
      end
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         pc_q          <= RESET_PC;
         inst_q        <= 32'h0000_0000;
         inst_pc_q     <= 32'h0000_0000;
         inst_valid_q  <= 1'b0;
         miss_count_q  <= {CNT_W{1'b0}};
         miss_cycles_q <= {CNT_W{1'b0}};
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         inst_q        <= inst_d;
         inst_pc_q     <= inst_pc_d;
         inst_valid_q  <= inst_valid_d;
         miss_count_q  <= miss_count_d;
         miss_cycles_q <= miss_cycles_d;
      end
   end

   assign ic_addr     = pc_q;
   assign inst        = inst_q;
   assign inst_pc     = inst_pc_q;
   assign inst_valid  = inst_valid_q;
   assign miss_count  = miss_count_q;
   assign miss_cycles = miss_cycles_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations plus a randomized run,
// all compared every cycle against a behavioural model of the fetch rules.
module tb_fetch_unit;
   localparam int CNT_W = 10;
   localparam int SAT   = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic [31:0]      ic_addr;
   logic [31:0]      ic_data = 32'h0;
   logic             ic_hit = 1'b0;
   logic             stall = 1'b0;
   logic             flush = 1'b0;
   logic [31:0]      redirect_pc = 32'h0;
   logic [31:0]      inst;
   logic [31:0]      inst_pc;
   logic             inst_valid;
   logic [CNT_W-1:0] miss_count;
   logic [CNT_W-1:0] miss_cycles;

   int errors = 0;
   int checks = 0;

   fetch_unit #(.RESET_PC(32'h0040_0000), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .ic_addr(ic_addr), .ic_data(ic_data), .ic_hit(ic_hit),
      .stall(stall), .flush(flush), .redirect_pc(redirect_pc), .inst(inst), .inst_pc(inst_pc),
      .inst_valid(inst_valid), .miss_count(miss_count), .miss_cycles(miss_cycles)
   );

   always #5 clk = ~clk;

   // Reference model: fetch address, last delivered word, whether a miss is outstanding.
   logic [31:0] m_pc = 32'h0040_0000;
   logic [31:0] m_inst = 32'h0;
   logic [31:0] m_ipc = 32'h0;
   bit          m_valid = 1'b0;
   bit          m_idle = 1'b1;
   bit          m_wait = 1'b0;
   int          m_mc = 0;
   int          m_mcy = 0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_pc = 32'h0040_0000; m_inst = 32'h0; m_ipc = 32'h0;
         m_valid = 1'b0; m_idle = 1'b1; m_wait = 1'b0; m_mc = 0; m_mcy = 0;
      end else begin
         if (m_wait && m_mcy < SAT) m_mcy = m_mcy + 1;
         if (flush) begin
            m_pc = {redirect_pc[31:2], 2'b00};
            m_valid = 1'b0; m_idle = 1'b0; m_wait = 1'b0;
         end else if (!stall) begin
            if (m_idle) begin
               m_idle = 1'b0;
            end else if (ic_hit) begin
               m_inst = ic_data; m_ipc = m_pc; m_valid = 1'b1;
               m_pc = m_pc + 32'd4; m_wait = 1'b0;
            end else begin
               m_valid = 1'b0;
               if (!m_wait) begin
                  m_wait = 1'b1;
                  if (m_mc < SAT) m_mc = m_mc + 1;
               end
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      chk("ic_addr", ic_addr, m_pc);
      chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_valid});
      chk("inst", inst, m_inst);
      chk("inst_pc", inst_pc, m_ipc);
      chk("miss_count", {{(32-CNT_W){1'b0}}, miss_count}, m_mc);
      chk("miss_cycles", {{(32-CNT_W){1'b0}}, miss_cycles}, m_mcy);
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic drive(input bit h, input bit s, input bit f, input logic [31:0] rpc);
      #1;
      ic_hit = h; stall = s; flush = f; redirect_pc = rpc;
      ic_data = ic_addr ^ 32'hA5A5_A5A5;
   endtask

   initial begin
      int mc_base;
      tick();
      chk("lit_reset_valid", {31'b0, inst_valid}, 32'd0);
      chk("lit_reset_addr", ic_addr, 32'h0040_0000);
      // Scenario 1: release reset with constant hits.
      drive(1'b1, 1'b0, 1'b0, 32'h0); reset = 1'b1;
      tick();
      chk("lit_idle_valid", {31'b0, inst_valid}, 32'd0);
      chk("lit_idle_addr", ic_addr, 32'h0040_0000);
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      tick();
      chk("lit_first_pc", inst_pc, 32'h0040_0000);
      chk("lit_first_inst", inst, 32'hA5E5_A5A5);
      chk("lit_first_valid", {31'b0, inst_valid}, 32'd1);
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      tick();
      chk("lit_second_pc", inst_pc, 32'h0040_0004);
      // Scenario 3: two stall cycles freeze the delivered word.
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      tick();
      chk("lit_stall1_pc", inst_pc, 32'h0040_0004);
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      tick();
      chk("lit_stall2_pc", inst_pc, 32'h0040_0004);
      chk("lit_stall2_valid", {31'b0, inst_valid}, 32'd1);
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      tick();
      chk("lit_after_stall_pc", inst_pc, 32'h0040_0008);
      // Scenario 2: redirect to 0x00400040, three miss cycles, then hit.
      drive(1'b1, 1'b0, 1'b1, 32'h0040_0040);
      tick();
      chk("lit_redirect_addr", ic_addr, 32'h0040_0040);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 1'b0, 32'h0);
         tick();
         chk("lit_bubble_valid", {31'b0, inst_valid}, 32'd0);
      end
      drive(1'b1, 1'b0, 1'b0, 32'h0); ic_data = 32'h0000_1234;
      tick();
      chk("lit_miss_inst", inst, 32'h0000_1234);
      chk("lit_miss_pc", inst_pc, 32'h0040_0040);
      chk("lit_miss_count", {{(32-CNT_W){1'b0}}, miss_count}, 32'd1);
      chk("lit_miss_cycles", {{(32-CNT_W){1'b0}}, miss_cycles}, 32'd3);
      // Scenario 4: flush while missing and stalled.
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      drive(1'b0, 1'b1, 1'b1, 32'h0030_E042);
      tick();
      chk("lit_flush_addr", ic_addr, 32'h0030_E040);
      chk("lit_flush_valid", {31'b0, inst_valid}, 32'd0);
      chk("lit_flush_mc", {{(32-CNT_W){1'b0}}, miss_count}, 32'd2);
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      tick();
      chk("lit_flush_deliver", inst_pc, 32'h0030_E040);
      // Scenario 5: PC wraps past the top of the address space.
      drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
      tick();
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      tick();
      chk("lit_top_pc", inst_pc, 32'hFFFF_FFFC);
      chk("lit_top_inst", inst, 32'h5A5A_5A59);
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      tick();
      chk("lit_wrap_pc", inst_pc, 32'h0000_0000);
      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2,
               $urandom_range(0, 19) == 0, $urandom);
         if ($urandom_range(0, 1) == 1) ic_data = $urandom;
         tick();
      end
      // Saturation: more miss events than the counter can hold.
      drive(1'b1, 1'b0, 1'b1, 32'h0000_1000);
      tick();
      mc_base = m_mc;
      for (int i = 0; i < SAT + 4; i++) begin
         drive(1'b0, 1'b0, 1'b0, 32'h0);
         tick();
         drive(1'b1, 1'b0, 1'b0, 32'h0);
         tick();
      end
      chk("lit_sat_count", {{(32-CNT_W){1'b0}}, miss_count}, SAT);
      chk("lit_sat_cycles", {{(32-CNT_W){1'b0}}, miss_cycles}, SAT);
      chk("lit_sat_base", (mc_base + SAT + 4 > SAT) ? 32'd1 : 32'd0, 32'd1);
      // Scenario 6: asynchronous reset while a miss is outstanding.
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      #2 reset = 1'b0;
      #1;
      chk("lit_areset_addr", ic_addr, 32'h0040_0000);
      chk("lit_areset_valid", {31'b0, inst_valid}, 32'd0);
      chk("lit_areset_inst", inst, 32'h0);
      chk("lit_areset_ipc", inst_pc, 32'h0);
      chk("lit_areset_mc", {{(32-CNT_W){1'b0}}, miss_count}, 32'd0);
      chk("lit_areset_mcy", {{(32-CNT_W){1'b0}}, miss_cycles}, 32'd0);
      tick();
      drive(1'b1, 1'b0, 1'b0, 32'h0); reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         drive(1'b1, 1'b0, 1'b0, 32'h0);
      end
      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
